// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma front end: letter encoding,
// default notches, sequencer state encoding and the mod-26 position step.
package enigma_pkg;

  typedef logic [4:0] letter_t;

  localparam int      NUM_LETTERS = 26;
  localparam letter_t LAST_LETTER = 5'd25;
  localparam letter_t LETTER_ERR  = 5'd31;

  localparam letter_t
    LTR_A = 5'd0,  LTR_B = 5'd1,  LTR_C = 5'd2,  LTR_D = 5'd3,  LTR_E = 5'd4,
    LTR_F = 5'd5,  LTR_G = 5'd6,  LTR_H = 5'd7,  LTR_I = 5'd8,  LTR_J = 5'd9,
    LTR_K = 5'd10, LTR_L = 5'd11, LTR_M = 5'd12, LTR_N = 5'd13, LTR_O = 5'd14,
    LTR_P = 5'd15, LTR_Q = 5'd16, LTR_R = 5'd17, LTR_S = 5'd18, LTR_T = 5'd19,
    LTR_U = 5'd20, LTR_V = 5'd21, LTR_W = 5'd22, LTR_X = 5'd23, LTR_Y = 5'd24,
    LTR_Z = 5'd25;

  localparam letter_t DEFAULT_NOTCH_R = LTR_V;
  localparam letter_t DEFAULT_NOTCH_M = LTR_E;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_DRIVE,
    S_CAPTURE
  } seq_state_t;

  function automatic logic legal_letter(input letter_t l);
    return (l <= LAST_LETTER);
  endfunction

  function automatic letter_t inc26(input letter_t p);
    return (p >= LAST_LETTER) ? LTR_A : letter_t'(p + 5'd1);
  endfunction

endpackage

// File: rtl/enigma_onehot_decode.sv
// Combinational 26-bit lamp/rotor vector to letter index, with a flag that
// is high only when exactly one bit is set.
module enigma_onehot_decode
  import enigma_pkg::*;
(
  input  logic [NUM_LETTERS-1:0] vec,
  output letter_t                index,
  output logic                   one_hot
);

  logic [4:0] hits;

  always_comb begin
    index = LTR_A;
    hits  = 5'd0;
    for (int i = 0; i < NUM_LETTERS; i++) begin
      if (vec[i]) begin
        index = letter_t'(i);
        hits  = hits + 5'd1;
      end
    end
    one_hot = (hits == 5'd1);
  end

endmodule

// File: rtl/enigma_key_sequencer.sv
// Key sequencer: steps the rotors (with middle-rotor double-step), drives the
// one-hot key into the rotor chain, waits for it to settle and reports the lamp.
module enigma_key_sequencer
  import enigma_pkg::*;
#(
  parameter letter_t NOTCH_R       = DEFAULT_NOTCH_R,
  parameter letter_t NOTCH_M       = DEFAULT_NOTCH_M,
  parameter int      SETTLE_CYCLES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   key_valid,
  input  letter_t                key_letter,
  output logic                   key_ready,
  input  logic                   load,
  input  letter_t                load_l,
  input  letter_t                load_m,
  input  letter_t                load_r,
  output letter_t                pos_l,
  output letter_t                pos_m,
  output letter_t                pos_r,
  output logic                   rot_set,
  output logic                   rotate_l,
  output logic                   rotate_m,
  output logic                   rotate_r,
  output logic [NUM_LETTERS-1:0] rotor_in,
  input  logic [NUM_LETTERS-1:0] rotor_out,
  output logic                   lamp_valid,
  output letter_t                lamp_letter,
  output logic                   error
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  seq_state_t       state, state_next;
  logic [CNT_W-1:0] settle_cnt;
  letter_t          key_q;
  logic             key_fire, load_fire, bad_key;
  letter_t          dec_index;
  logic             dec_one_hot;

  enigma_onehot_decode u_decode (
    .vec     (rotor_out),
    .index   (dec_index),
    .one_hot (dec_one_hot)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    key_fire   = 1'b0;
    load_fire  = 1'b0;
    bad_key    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (load) begin
          load_fire = 1'b1;
        end else if (key_valid) begin
          if (legal_letter(key_letter)) begin
            key_fire   = 1'b1;
            state_next = S_STEP;
          end else begin
            bad_key = 1'b1;
          end
        end
      end
      S_STEP:    state_next = S_DRIVE;
      S_DRIVE:   if (settle_cnt == '0) state_next = S_CAPTURE;
      S_CAPTURE: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Registered outputs; rotate pulses are computed from the positions seen at
  // key acceptance and applied to the positions at the end of STEP.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_ready   <= 1'b1;
      pos_l       <= LTR_A;
      pos_m       <= LTR_A;
      pos_r       <= LTR_A;
      rot_set     <= 1'b0;
      rotate_l    <= 1'b0;
      rotate_m    <= 1'b0;
      rotate_r    <= 1'b0;
      rotor_in    <= '0;
      lamp_valid  <= 1'b0;
      lamp_letter <= LTR_A;
      error       <= 1'b0;
      key_q       <= LTR_A;
      settle_cnt  <= '0;
    end else begin
      key_ready  <= (state_next == S_IDLE);
      rot_set    <= load_fire;
      error      <= bad_key;
      lamp_valid <= 1'b0;
      rotate_l   <= 1'b0;
      rotate_m   <= 1'b0;
      rotate_r   <= 1'b0;

      if (load_fire) begin
        pos_l <= legal_letter(load_l) ? load_l : LTR_A;
        pos_m <= legal_letter(load_m) ? load_m : LTR_A;
        pos_r <= legal_letter(load_r) ? load_r : LTR_A;
      end

      if (key_fire) begin
        key_q    <= key_letter;
        rotate_r <= 1'b1;
        rotate_m <= (pos_r == NOTCH_R) || (pos_m == NOTCH_M);
        rotate_l <= (pos_m == NOTCH_M);
      end

      unique case (state)
        S_STEP: begin
          if (rotate_r) pos_r <= inc26(pos_r);
          if (rotate_m) pos_m <= inc26(pos_m);
          if (rotate_l) pos_l <= inc26(pos_l);
          rotor_in   <= NUM_LETTERS'(1) << key_q;
          settle_cnt <= CNT_W'(SETTLE_CYCLES - 1);
        end
        S_DRIVE: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
        end
        S_CAPTURE: begin
          rotor_in   <= '0;
          lamp_valid <= 1'b1;
          if (dec_one_hot) begin
            lamp_letter <= dec_index;
          end else begin
            lamp_letter <= LETTER_ERR;
            error       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_key_sequencer.sv
// Self-checking bench for enigma_key_sequencer: directed rotor-stepping cases
// plus randomized keys/loads against a mod-26 positional reference model.
module tb_enigma_key_sequencer;
  import enigma_pkg::*;

  localparam int SETTLE = 2;

  logic          clock = 1'b0;
  logic          reset, key_valid, load, key_ready, rot_set;
  logic          rotate_l, rotate_m, rotate_r, lamp_valid, error;
  letter_t       key_letter, load_l, load_m, load_r, pos_l, pos_m, pos_r, lamp_letter;
  logic [25:0]   rotor_in, rotor_out;
  logic          fault_mode;

  int n_cmp = 0;
  int n_bad = 0;
  int m_l, m_m, m_r;

  enigma_key_sequencer #(.NOTCH_R(5'd21), .NOTCH_M(5'd4), .SETTLE_CYCLES(SETTLE)) dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_letter(key_letter),
    .key_ready(key_ready), .load(load), .load_l(load_l), .load_m(load_m), .load_r(load_r),
    .pos_l(pos_l), .pos_m(pos_m), .pos_r(pos_r), .rot_set(rot_set),
    .rotate_l(rotate_l), .rotate_m(rotate_m), .rotate_r(rotate_r),
    .rotor_in(rotor_in), .rotor_out(rotor_out), .lamp_valid(lamp_valid),
    .lamp_letter(lamp_letter), .error(error)
  );

  always #5 clock = ~clock;

  // Stand-in rotor chain: shifts the letter by three, or returns a broken vector.
  always_comb begin
    rotor_out = '0;
    if (fault_mode) rotor_out = 26'h3;
    else
      for (int i = 0; i < 26; i++)
        if (rotor_in[i]) rotor_out = 26'd1 << ((i + 3) % 26);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_pos(input string tag);
    check({tag, ".pos_l"}, 32'(pos_l), 32'(m_l));
    check({tag, ".pos_m"}, 32'(pos_m), 32'(m_m));
    check({tag, ".pos_r"}, 32'(pos_r), 32'(m_r));
  endtask

  task automatic do_load(input int l, input int m, input int r);
    load = 1'b1; load_l = letter_t'(l); load_m = letter_t'(m); load_r = letter_t'(r);
    tick();
    load = 1'b0;
    m_l = (l < 26) ? l : 0;
    m_m = (m < 26) ? m : 0;
    m_r = (r < 26) ? r : 0;
    check("load.rot_set", 32'(rot_set), 1);
    check("load.ready", 32'(key_ready), 1);
    check_pos("load");
    tick();
    check("load.rot_set_end", 32'(rot_set), 0);
  endtask

  // One legal key from acceptance edge to lamp cycle; optional ignored noise on inputs.
  task automatic do_key(input int letter, input bit fault, input bit noise);
    bit er, em, el;
    fault_mode = fault;
    er = 1'b1;
    em = (m_r == 21) || (m_m == 4);
    el = (m_m == 4);
    key_valid = 1'b1; key_letter = letter_t'(letter);
    tick();
    key_valid = 1'b0;
    check("step.ready", 32'(key_ready), 0);
    check("step.rot", {29'd0, rotate_l, rotate_m, rotate_r}, {29'd0, el, em, er});
    check("step.rotor_in", 32'(rotor_in), 0);
    check_pos("step");
    if (er) m_r = (m_r + 1) % 26;
    if (em) m_m = (m_m + 1) % 26;
    if (el) m_l = (m_l + 1) % 26;
    if (noise) begin
      load = 1'b1; load_l = 5'd7; load_m = 5'd8; load_r = 5'd9;
      key_valid = 1'b1; key_letter = 5'd1;
    end
    for (int c = 0; c < SETTLE + 1; c++) begin
      tick();
      if (c == SETTLE - 1) begin load = 1'b0; key_valid = 1'b0; end
      check("drv.rotor_in", 32'(rotor_in), 32'(26'd1 << letter));
      check("drv.rot", {29'd0, rotate_l, rotate_m, rotate_r}, 0);
      check("drv.lamp_valid", 32'(lamp_valid), 0);
      check("drv.ready", 32'(key_ready), 0);
    end
    check_pos("drv");
    tick();
    check("lamp.valid", 32'(lamp_valid), 1);
    check("lamp.letter", 32'(lamp_letter), fault ? 32'd31 : 32'((letter + 3) % 26));
    check("lamp.error", 32'(error), fault ? 1 : 0);
    check("lamp.ready", 32'(key_ready), 1);
    check("lamp.rotor_in", 32'(rotor_in), 0);
    check_pos("lamp");
    fault_mode = 1'b0;
  endtask

  task automatic do_bad_key(input int letter);
    key_valid = 1'b1; key_letter = letter_t'(letter);
    tick();
    key_valid = 1'b0;
    check("bad.error", 32'(error), 1);
    check("bad.ready", 32'(key_ready), 1);
    check("bad.rot", {29'd0, rotate_l, rotate_m, rotate_r}, 0);
    check("bad.lamp_valid", 32'(lamp_valid), 0);
    check_pos("bad");
    tick();
    check("bad.error_end", 32'(error), 0);
    check("bad.ready2", 32'(key_ready), 1);
  endtask

  initial begin
    reset = 1'b1; key_valid = 1'b0; key_letter = '0; load = 1'b0;
    load_l = '0; load_m = '0; load_r = '0; fault_mode = 1'b0;
    m_l = 0; m_m = 0; m_r = 0;
    tick(); tick();
    reset = 1'b0;
    check("rst.ready", 32'(key_ready), 1);
    check("rst.rotor_in", 32'(rotor_in), 0);
    check("rst.lamp", {26'd0, lamp_valid, lamp_letter}, 0);
    check("rst.pulses", {27'd0, rot_set, rotate_l, rotate_m, rotate_r, error}, 0);
    check_pos("rst");

    do_key(0, 1'b0, 1'b0);                 // AAA -> AAB
    do_load(0, 3, 20);                     // ADU
    do_key(4, 1'b0, 1'b0);                 // ADV
    do_key(11, 1'b0, 1'b0);                // AEW
    do_key(25, 1'b0, 1'b0);                // BFX, left steps
    check("dbl.final", {17'd0, pos_l, pos_m, pos_r}, {17'd0, 5'd1, 5'd5, 5'd23});
    do_load(0, 0, 25);
    do_key(7, 1'b0, 1'b0);
    check("wrap.pos_r", 32'(pos_r), 0);
    do_bad_key(27);
    do_key(2, 1'b1, 1'b0);                 // broken chain vector
    do_load(30, 28, 26);                   // out-of-range loads reduce to 0

    // Reset in the middle of DRIVE.
    key_valid = 1'b1; key_letter = 5'd9;
    tick();
    key_valid = 1'b0;
    tick();
    check("mid.rotor_in", 32'(rotor_in), 32'(26'd1 << 9));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_l = 0; m_m = 0; m_r = 0;
    check("mid.ready", 32'(key_ready), 1);
    check("mid.rotor_in0", 32'(rotor_in), 0);
    check("mid.lamp_valid", 32'(lamp_valid), 0);
    check_pos("mid");
    for (int c = 0; c < SETTLE + 2; c++) begin
      tick();
      check("mid.no_lamp", 32'(lamp_valid), 0);
    end

    for (int it = 0; it < 60; it++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 2)       do_load($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      else if (sel == 2) do_bad_key($urandom_range(26, 31));
      else               do_key($urandom_range(0, 25), sel == 3, sel == 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
